// File: rtl/fetch_sequencer_if.sv
// Handshake and memory bus between the fetch sequencer (master) and its
// instruction memory / ALU / consumer environment (slave).
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int ULA_WIDTH         = 24,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 8
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic                         mem_rd;
  logic [INSTRUCTION_WIDTH-1:0] mem_data;
  logic [ULA_WIDTH-1:0]         ula_in;
  logic                         redirect_valid;
  logic [1:0]                   redirect_sel;
  logic                         instr_ready;
  logic                         instr_valid;
  logic [DATA_WIDTH-1:0]        instr_out;
  logic [DATA_WIDTH-1:0]        arg_out;
  logic [ADDR_WIDTH-1:0]        pc_out;
  logic [SP_W-1:0]              sp_out;
  logic                         stack_ovf;
  logic                         stack_unf;
  logic                         halted;

  modport master (
    output mem_addr, mem_rd, instr_valid, instr_out, arg_out, pc_out,
           sp_out, stack_ovf, stack_unf, halted,
    input  mem_data, ula_in, redirect_valid, redirect_sel, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd, instr_valid, instr_out, arg_out, pc_out,
           sp_out, stack_ovf, stack_unf, halted,
    output mem_data, ula_in, redirect_valid, redirect_sel, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches from a synchronous memory, holds each
// instruction behind a valid/ready handshake and applies jump/call/return/halt.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FETCH | mem_rd asserted, mem_addr = PC
// S_WAIT  | memory word arriving; latch opcode, argument and PC
// S_VALID | instruction held until instr_ready; redirect applied on accept
// S_HALT  | stopped, no fetches until reset
module fetch_sequencer #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int ULA_WIDTH         = 24,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 8,
  parameter int RESET_PC          = 0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int PTR_W = $clog2(STACK_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_VALID, S_HALT} state_t;

  localparam logic [1:0] SEL_JUMP   = 2'b00;
  localparam logic [1:0] SEL_CALL   = 2'b01;
  localparam logic [1:0] SEL_RETURN = 2'b10;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_out_q;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [ADDR_WIDTH-1:0] ula_target;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] arg_q;
  logic [SP_W-1:0]       sp;
  logic [SP_W-1:0]       sp_dec;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  hs;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  mem_rd_c;
  logic                  valid_c;
  logic                  halted_c;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  wire unused_ula_hi = &{1'b0, bus.ula_in[ULA_WIDTH-1:ADDR_WIDTH]};

  assign hs         = (state == S_VALID) && bus.instr_ready;
  assign pc_inc     = pc_out_q + 1'b1;
  assign ula_target = bus.ula_in[ADDR_WIDTH-1:0];
  assign full       = (sp == SP_W'(STACK_DEPTH));
  assign empty      = (sp == '0);
  assign sp_dec     = sp - 1'b1;
  assign ret_addr   = stack_mem[sp_dec[PTR_W-1:0]];
  assign do_push    = hs && bus.redirect_valid && (bus.redirect_sel == SEL_CALL) && !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_VALID;
      S_VALID: begin
        if (bus.instr_ready) begin
          if (bus.redirect_valid && (bus.redirect_sel == 2'b11)) state_nxt = S_HALT;
          else                                                   state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_HALT;
    endcase
  end

  always_comb begin
    mem_rd_c = 1'b0;
    valid_c  = 1'b0;
    halted_c = 1'b0;
    case (state)
      S_FETCH: mem_rd_c = 1'b1;
      S_VALID: valid_c  = 1'b1;
      S_HALT:  halted_c = 1'b1;
      default: ;
    endcase
  end

  // Stack contents are deliberately not reset; only sp defines what is live.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[sp[PTR_W-1:0]] <= pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= ADDR_WIDTH'(RESET_PC);
      pc_out_q <= '0;
      instr_q  <= '0;
      arg_q    <= '0;
      sp       <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        instr_q  <= bus.mem_data[INSTRUCTION_WIDTH-1:DATA_WIDTH];
        arg_q    <= bus.mem_data[DATA_WIDTH-1:0];
        pc_out_q <= pc;
      end
      if (hs) begin
        if (!bus.redirect_valid) begin
          pc <= pc_inc;
        end else begin
          case (bus.redirect_sel)
            SEL_JUMP: pc <= ula_target;
            SEL_CALL: begin
              pc <= ula_target;
              if (full) ovf_q <= 1'b1;
              else      sp    <= sp + 1'b1;
            end
            SEL_RETURN: begin
              if (empty) begin
                unf_q <= 1'b1;
                pc    <= pc_inc;
              end else begin
                pc <= ret_addr;
                sp <= sp_dec;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // mem_rd is masked by rst because reset parks the FSM in S_FETCH.
  assign bus.mem_rd      = mem_rd_c & ~rst;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = valid_c;
  assign bus.halted      = halted_c;
  assign bus.instr_out   = instr_q;
  assign bus.arg_out     = arg_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.sp_out      = sp;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction-by-instruction vector table
// plus hand sequences for reset, latency, backpressure and halt.
module tb_fetch_sequencer;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [4096];

  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
  end

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    if (a == 12'h000) return 16'h1122;
    if (a == 12'h001) return 16'h3344;
    return {a[7:0], a[11:4] ^ 8'hC3};
  endfunction

  typedef struct {
    logic [11:0] pc;
    logic [3:0]  sp;
    logic        ovf;
    logic        unf;
    logic        rv;
    logic [1:0]  sel;
    logic [23:0] ula;
    logic [11:0] nxt;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(input logic [11:0] pc, input int sp, input bit ovf,
                              input bit unf, input bit rv, input logic [1:0] sel,
                              input logic [23:0] ula, input logic [11:0] nxt);
    vec_t v;
    v.pc = pc; v.sp = 4'(sp); v.ovf = ovf; v.unf = unf;
    v.rv = rv; v.sel = sel; v.ula = ula; v.nxt = nxt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.instr_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int          cyc;
    logic [15:0] w;

    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 4096; a++) mem[a] = mem_word(12'(a));

    // pc, sp, ovf, unf, rv, sel, ula, next fetch address
    vt[0] = mk(12'h000, 0, 0, 0, 0, 2'b00, 24'h000000, 12'h001);
    vt[1] = mk(12'h001, 0, 0, 0, 1, 2'b00, 24'h000010, 12'h010);
    vt[2] = mk(12'h010, 0, 0, 0, 1, 2'b01, 24'h000200, 12'h200);
    vt[3] = mk(12'h200, 1, 0, 0, 0, 2'b01, 24'h000777, 12'h201);
    vt[4] = mk(12'h201, 1, 0, 0, 1, 2'b10, 24'h000000, 12'h011);
    vt[5] = mk(12'h011, 0, 0, 0, 1, 2'b10, 24'h000000, 12'h012);
    vt[6] = mk(12'h012, 0, 0, 1, 1, 2'b00, 24'hABCFFF, 12'hFFF);
    vt[7] = mk(12'hFFF, 0, 0, 1, 0, 2'b00, 24'h000000, 12'h000);
    vt[8] = mk(12'h000, 0, 0, 1, 1, 2'b00, 24'h000100, 12'h100);
    vt[9] = mk(12'h100, 0, 0, 1, 1, 2'b01, 24'h000300, 12'h300);
    for (int k = 1; k <= 8; k++)
      vt[9+k] = mk(12'h300 + 12'(k - 1), k, 0, 1, 1, 2'b01,
                   24'h000300 + 24'(k), 12'h300 + 12'(k));
    // ninth call overflowed; top entry is the return address pushed at 0x306
    vt[18] = mk(12'h308, 8, 1, 1, 1, 2'b10, 24'h000000, 12'h307);
    vt[19] = mk(12'h307, 7, 1, 1, 1, 2'b11, 24'h000000, 12'h000);

    rst                = 1'b1;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_sel   = 2'b00;
    bus.ula_in         = '0;
    bus.mem_data       = '0;

    repeat (2) @(negedge clk);
    chk("rst_mem_rd",      32'(bus.mem_rd),      32'd0);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_halted",      32'(bus.halted),      32'd0);
    chk("rst_sp",          32'(bus.sp_out),      32'd0);
    chk("rst_pc_out",      32'(bus.pc_out),      32'd0);
    chk("rst_flags",       32'({bus.stack_ovf, bus.stack_unf}), 32'd0);
    chk("rst_mem_addr",    32'(bus.mem_addr),    32'd0);
    rst = 1'b0;

    wait_valid(cyc);
    chk("first_latency", 32'(cyc), 32'd2);

    // Backpressure with a halt redirect presented that must be ignored.
    bus.redirect_valid = 1'b1;
    bus.redirect_sel   = 2'b11;
    bus.ula_in         = 24'h000555;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_valid",  32'(bus.instr_valid), 32'd1);
      chk("bp_pc_out", 32'(bus.pc_out),      32'h000);
      chk("bp_instr",  32'(bus.instr_out),   32'h11);
      chk("bp_arg",    32'(bus.arg_out),     32'h22);
      chk("bp_mem_rd", 32'(bus.mem_rd),      32'd0);
      chk("bp_addr",   32'(bus.mem_addr),    32'h000);
    end

    for (int i = 0; i < 20; i++) begin
      wait_valid(cyc);
      if (i > 0) chk("latency", 32'(cyc), 32'd2);
      chk("valid", 32'(bus.instr_valid), 32'd1);
      w = mem_word(vt[i].pc);
      chk("pc_out", 32'(bus.pc_out),    32'(vt[i].pc));
      chk("instr",  32'(bus.instr_out), 32'(w[15:8]));
      chk("arg",    32'(bus.arg_out),   32'(w[7:0]));
      chk("sp",     32'(bus.sp_out),    32'(vt[i].sp));
      chk("ovf",    32'(bus.stack_ovf), 32'(vt[i].ovf));
      chk("unf",    32'(bus.stack_unf), 32'(vt[i].unf));

      bus.instr_ready    = 1'b1;
      bus.redirect_valid = vt[i].rv;
      bus.redirect_sel   = vt[i].sel;
      bus.ula_in         = vt[i].ula;
      @(posedge clk);
      #1;
      // Noise outside the handshake: a call request with ready low.
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_sel   = 2'b01;
      bus.ula_in         = 24'h000ABC;

      if (vt[i].rv && vt[i].sel == 2'b11) begin
        chk("halt_halted", 32'(bus.halted),      32'd1);
        chk("halt_valid",  32'(bus.instr_valid), 32'd0);
        repeat (4) begin
          @(posedge clk);
          #1;
          chk("halt_mem_rd", 32'(bus.mem_rd),  32'd0);
          chk("halt_stay",   32'(bus.halted),  32'd1);
          chk("halt_sp",     32'(bus.sp_out),  32'd7);
        end
      end else begin
        chk("fetch_rd",   32'(bus.mem_rd),   32'd1);
        chk("fetch_addr", 32'(bus.mem_addr), 32'(vt[i].nxt));
      end
    end

    // Asynchronous reset from HALT, away from any clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("hrst_halted", 32'(bus.halted),      32'd0);
    chk("hrst_sp",     32'(bus.sp_out),      32'd0);
    chk("hrst_flags",  32'({bus.stack_ovf, bus.stack_unf}), 32'd0);
    chk("hrst_pc_out", 32'(bus.pc_out),      32'd0);
    chk("hrst_instr",  32'(bus.instr_out),   32'd0);
    chk("hrst_mem_rd", 32'(bus.mem_rd),      32'd0);
    chk("hrst_addr",   32'(bus.mem_addr),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    wait_valid(cyc);
    chk("restart_latency", 32'(cyc),           32'd2);
    chk("restart_pc_out",  32'(bus.pc_out),    32'h000);
    chk("restart_instr",   32'(bus.instr_out), 32'h11);
    chk("restart_arg",     32'(bus.arg_out),   32'h22);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
